// File: rtl/pkt_node_port.sv
// pkt_node_port: endpoint port for the 10-bit packet switch fabric.
// Samples one link word per cycle. Words addressed to NODE_ID are ejected to
// the local receive port. Idle words are free slots, and so are words that
// were just ejected. Any other word is forwarded unchanged. Locally offered
// packets are buffered in a small TX FIFO and injected into free slots.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tx_valid/tx_ready     local packet offer handshake (tx_ready = FIFO not full)
//   tx_prio/dest/data     offered packet fields
//   tx_err                one-cycle pulse after an offer with an illegal destination
//   link_in / link_out    word from switch output / registered word to switch input
//   rx_valid/prio/data    ejected packet (prio/data hold when rx_valid is low)
//   fifo_count            TX FIFO occupancy
module pkt_node_port #(
  parameter logic [2:0]  NODE_ID    = 3'b010,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_prio,
  input  logic [2:0]                    tx_dest,
  input  logic [5:0]                    tx_data,
  output logic                          tx_err,
  input  logic [9:0]                    link_in,
  output logic [9:0]                    link_out,
  output logic                          rx_valid,
  output logic                          rx_prio,
  output logic [5:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 10;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] link_out_q, link_out_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_prio_q, rx_prio_d;
  logic [5:0]        rx_data_q, rx_data_d;
  logic              tx_err_q, tx_err_d;

  logic [2:0] link_dest;
  logic       is_idle, is_eject, slot_free;
  logic       dest_ok, push, pop;

  // Ready depends on the registered count only, so there is no path from tx_valid.
  assign tx_ready = (count_q != CNT_W'(FIFO_DEPTH));

  // Classify the link word and derive the FIFO handshakes.
  always_comb begin
    link_dest = link_in[8:6];
    is_idle   = (link_dest == 3'b000);
    is_eject  = (link_dest == NODE_ID);
    slot_free = is_idle | is_eject;
    dest_ok   = (tx_dest != 3'b000) && (tx_dest != NODE_ID);
    push      = tx_valid & tx_ready & dest_ok;
    pop       = slot_free & (count_q != '0);
  end

  // Next-state logic for the link, the receive port and the FIFO bookkeeping.
  always_comb begin
    link_out_d = '0;
    rx_valid_d = is_eject;
    rx_prio_d  = rx_prio_q;
    rx_data_d  = rx_data_q;
    tx_err_d   = tx_valid & tx_ready & ~dest_ok;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    if (is_eject) begin
      rx_prio_d = link_in[9];
      rx_data_d = link_in[5:0];
    end

    // Forwarded traffic always owns the slot; injection only fills free slots.
    if (!slot_free) begin
      link_out_d = link_in;
    end else if (pop) begin
      link_out_d = mem_q[rd_ptr_q];
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // FIFO storage. The head is read from registered contents, so a packet
  // pushed at an edge cannot also leave at that edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tx_prio, tx_dest, tx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      link_out_q <= '0;
      rx_valid_q <= 1'b0;
      rx_prio_q  <= 1'b0;
      rx_data_q  <= '0;
      tx_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      link_out_q <= link_out_d;
      rx_valid_q <= rx_valid_d;
      rx_prio_q  <= rx_prio_d;
      rx_data_q  <= rx_data_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign link_out   = link_out_q;
  assign rx_valid   = rx_valid_q;
  assign rx_prio    = rx_prio_q;
  assign rx_data    = rx_data_q;
  assign tx_err     = tx_err_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_pkt_node_port.sv
// Directed bench for pkt_node_port with NODE_ID=010 and FIFO_DEPTH=4.
module tb_pkt_node_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_prio;
  logic [2:0] tx_dest;
  logic [5:0] tx_data;
  logic       tx_err;
  logic [9:0] link_in;
  logic [9:0] link_out;
  logic       rx_valid;
  logic       rx_prio;
  logic [5:0] rx_data;
  logic [2:0] fifo_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pkt_node_port #(.NODE_ID(3'b010), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_prio(tx_prio),
    .tx_dest(tx_dest), .tx_data(tx_data), .tx_err(tx_err),
    .link_in(link_in), .link_out(link_out),
    .rx_valid(rx_valid), .rx_prio(rx_prio), .rx_data(rx_data),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic [9:0] link;
    logic       tv;
    logic       tp;
    logic [2:0] td;
    logic [5:0] tdat;
    logic [9:0] e_link;
    logic       e_rxv;
    logic       e_rxp;
    logic [5:0] e_rxd;
    logic       e_err;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [9:0] link, logic tv, logic tp, logic [2:0] td,
                              logic [5:0] tdat, logic [9:0] e_link, logic e_rxv,
                              logic e_rxp, logic [5:0] e_rxd, logic e_err,
                              logic [2:0] e_cnt);
    vec_t v;
    v.link = link; v.tv = tv; v.tp = tp; v.td = td; v.tdat = tdat;
    v.e_link = e_link; v.e_rxv = e_rxv; v.e_rxp = e_rxp; v.e_rxd = e_rxd;
    v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] link, input logic tv, input logic tp,
                       input logic [2:0] td, input logic [5:0] tdat);
    link_in = link; tx_valid = tv; tx_prio = tp; tx_dest = td; tx_data = tdat;
  endtask

  logic [9:0] pk[5];

  initial begin
    rst_n = 1'b0;
    drive(10'h3FF, 1'b1, 1'b1, 3'b100, 6'h3F);

    // Reset holds the outputs at their idle values despite active inputs.
    tick(); tick();
    chk("rst_link_out", 32'(link_out), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h1);
    chk("rst_count",    32'(fifo_count), 32'h0);
    chk("rst_tx_err",   32'(tx_err), 32'h0);
    chk("rst_rx_data",  32'(rx_data), 32'h0);

    // First edge after release is a normal forwarding edge.
    rst_n = 1'b1;
    drive(10'h0C0, 1'b0, 1'b0, 3'b000, 6'h00);
    tick();
    chk("post_rst_fwd", 32'(link_out), 32'h0C0);
    drive(10'h000, 1'b0, 1'b0, 3'b000, 6'h00);
    tick();
    chk("post_rst_idle", 32'(link_out), 32'h0);

    //              link     tv tp td      data   e_link   rxv rxp rxd    err cnt
    vecs[0]  = mk(10'h2A5, 0, 0, 3'b000, 6'h00, 10'h000, 1, 1, 6'h25, 0, 3'd0); // eject
    vecs[1]  = mk(10'h0E3, 0, 0, 3'b000, 6'h00, 10'h0E3, 0, 1, 6'h25, 0, 3'd0); // forward
    vecs[2]  = mk(10'h000, 1, 0, 3'b100, 6'h11, 10'h000, 0, 1, 6'h25, 0, 3'd1); // push
    vecs[3]  = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h111, 0, 1, 6'h25, 0, 3'd0); // inject
    vecs[4]  = mk(10'h000, 1, 0, 3'b000, 6'h05, 10'h000, 0, 1, 6'h25, 1, 3'd0); // dest 000
    vecs[5]  = mk(10'h000, 1, 1, 3'b010, 6'h3F, 10'h000, 0, 1, 6'h25, 1, 3'd0); // dest self
    vecs[6]  = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h000, 0, 1, 6'h25, 0, 3'd0);
    vecs[7]  = mk(10'h0C0, 1, 1, 3'b101, 6'h0A, 10'h0C0, 0, 1, 6'h25, 0, 3'd1); // blocked
    vecs[8]  = mk(10'h0C0, 1, 0, 3'b110, 6'h15, 10'h0C0, 0, 1, 6'h25, 0, 3'd2);
    vecs[9]  = mk(10'h087, 1, 0, 3'b001, 6'h33, 10'h34A, 1, 0, 6'h07, 0, 3'd2); // push+pop
    vecs[10] = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h195, 0, 0, 6'h07, 0, 3'd1);
    vecs[11] = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h073, 0, 0, 6'h07, 0, 3'd0);
    vecs[12] = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h000, 0, 0, 6'h07, 0, 3'd0);
    vecs[13] = mk(10'h2A5, 0, 0, 3'b000, 6'h00, 10'h000, 1, 1, 6'h25, 0, 3'd0); // b2b eject
    vecs[14] = mk(10'h087, 0, 0, 3'b000, 6'h00, 10'h000, 1, 0, 6'h07, 0, 3'd0);
    vecs[15] = mk(10'h000, 0, 0, 3'b000, 6'h00, 10'h000, 0, 0, 6'h07, 0, 3'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].link, vecs[i].tv, vecs[i].tp, vecs[i].td, vecs[i].tdat);
      tick();
      chk($sformatf("v%0d_link_out", i), 32'(link_out),   32'(vecs[i].e_link));
      chk($sformatf("v%0d_rx_valid", i), 32'(rx_valid),   32'(vecs[i].e_rxv));
      chk($sformatf("v%0d_rx_prio", i),  32'(rx_prio),    32'(vecs[i].e_rxp));
      chk($sformatf("v%0d_rx_data", i),  32'(rx_data),    32'(vecs[i].e_rxd));
      chk($sformatf("v%0d_tx_err", i),   32'(tx_err),     32'(vecs[i].e_err));
      chk($sformatf("v%0d_count", i),    32'(fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_tx_ready", i), 32'(tx_ready),   32'(vecs[i].e_cnt != 3'd4));
    end

    // Full FIFO under continuous forwarding, then drain in order.
    pk[0] = {1'b0, 3'b001, 6'h10};
    pk[1] = {1'b1, 3'b011, 6'h11};
    pk[2] = {1'b0, 3'b100, 6'h12};
    pk[3] = {1'b1, 3'b101, 6'h13};
    pk[4] = {1'b0, 3'b111, 6'h14};
    for (int i = 0; i < 4; i++) begin
      drive(10'h0C0, 1'b1, pk[i][9], pk[i][8:6], pk[i][5:0]);
      tick();
      chk($sformatf("fill%0d_count", i), 32'(fifo_count), 32'(i + 1));
      chk($sformatf("fill%0d_link", i),  32'(link_out),   32'h0C0);
    end
    chk("full_tx_ready", 32'(tx_ready), 32'h0);
    drive(10'h0C0, 1'b1, pk[4][9], pk[4][8:6], pk[4][5:0]);
    tick(); tick();
    chk("held_count",  32'(fifo_count), 32'h4);
    chk("held_tx_err", 32'(tx_err), 32'h0);
    chk("held_ready",  32'(tx_ready), 32'h0);

    // Link goes idle: pop without push, then the held packet is accepted.
    link_in = 10'h000;
    tick();
    chk("drain0_link",  32'(link_out), 32'(pk[0]));
    chk("drain0_count", 32'(fifo_count), 32'h3);
    chk("drain0_ready", 32'(tx_ready), 32'h1);
    tick();
    chk("drain1_link",  32'(link_out), 32'(pk[1]));
    chk("drain1_count", 32'(fifo_count), 32'h3);
    tx_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      tick();
      chk($sformatf("drain%0d_link", i),  32'(link_out),   32'(pk[i]));
      chk($sformatf("drain%0d_count", i), 32'(fifo_count), 32'(4 - i));
    end
    tick();
    chk("drained_link", 32'(link_out), 32'h0);

    // Mid-operation reset discards queued packets and the in-flight word.
    drive(10'h0C0, 1'b1, 1'b0, 3'b011, 6'h2A);
    tick(); tick();
    chk("pre_rst_count", 32'(fifo_count), 32'h2);
    tx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(fifo_count), 32'h0);
    chk("async_rst_link",  32'(link_out), 32'h0);
    tick();
    rst_n   = 1'b1;
    link_in = 10'h000;
    tick();
    chk("after_rst_link",  32'(link_out), 32'h0);
    chk("after_rst_count", 32'(fifo_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
